pwm_capture: RTL and testbench

//   Receive-side counterpart of the PWM generator: measures period and high time of an

---
 rtl/pwm_capture.sv | 211 +++++++++++++++++++++
 tb/tb_pwm_capture.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of an asynchronous PWM input in clk cycles.
// Define PWM_CAP_IRQ_EN to add the irq output and the CTRL.IE bit.
module pwm_capture #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wen,
  input  logic [3:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  input  logic       pwm_in
`ifdef PWM_CAP_IRQ_EN
  ,
  output logic       irq
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_HIGH,
    ST_LOW
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   s, rise, fall;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] high_acc_q, high_acc_d;
  logic [CNT_W-1:0] per_q, high_q;

  logic en_q, freeze_q;
`ifdef PWM_CAP_IRQ_EN
  logic ie_q;
`endif
  logic vld_q, tmo_q, ovr_q;

  logic commit, tmo_hit, tmo_stuck_high;
  logic ctrl_wr, stat_wr;
  logic vld_clr, tmo_clr, ovr_clr;

  logic [15:0] per16, high16;
  logic        unused_wdata;

  assign unused_wdata = ^wdata[7:3];

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~prev_q;
  assign fall = ~s & prev_q;

  assign ctrl_wr = wen && (addr == 4'h8);
  assign stat_wr = wen && (addr == 4'h9);
  assign vld_clr = stat_wr & wdata[0];
  assign tmo_clr = stat_wr & wdata[1];
  assign ovr_clr = stat_wr & wdata[2];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      prev_q <= s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      high_acc_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      high_acc_q <= high_acc_d;
    end
  end

  // cnt keeps running across the falling edge so that at the next rise it holds the full period
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    high_acc_d     = high_acc_q;
    commit         = 1'b0;
    tmo_hit        = 1'b0;
    tmo_stuck_high = 1'b0;
    if (!en_q) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_ARM;
        ST_ARM: begin
          if (rise) begin
            cnt_d   = CNT_ONE;
            state_d = ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (fall) begin
            high_acc_d = cnt_q;
            cnt_d      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
            state_d    = ST_LOW;
          end else if (cnt_q == CNT_MAX) begin
            tmo_hit        = 1'b1;
            tmo_stuck_high = 1'b1;
            cnt_d          = '0;
            state_d        = ST_ARM;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_LOW: begin
          if (rise) begin
            commit  = 1'b1;
            cnt_d   = CNT_ONE;
            state_d = ST_HIGH;
          end else if (cnt_q == CNT_MAX) begin
            tmo_hit = 1'b1;
            cnt_d   = '0;
            state_d = ST_ARM;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q     <= 1'b0;
      freeze_q <= 1'b0;
`ifdef PWM_CAP_IRQ_EN
      ie_q     <= 1'b0;
`endif
    end else if (ctrl_wr) begin
      en_q     <= wdata[0];
      freeze_q <= wdata[1];
`ifdef PWM_CAP_IRQ_EN
      ie_q     <= wdata[2];
`endif
    end
  end

  // A clear of VLD in the commit cycle means software has consumed the old result: no overrun
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= 1'b0;
      tmo_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      vld_q <= commit | (vld_q & ~vld_clr);
      tmo_q <= tmo_hit | (tmo_q & ~tmo_clr);
      ovr_q <= (commit & vld_q & ~vld_clr) | (ovr_q & ~ovr_clr);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      per_q  <= '0;
      high_q <= '0;
    end else if (!freeze_q) begin
      if (commit) begin
        per_q  <= cnt_q;
        high_q <= high_acc_q;
      end else if (tmo_hit) begin
        per_q  <= '0;
        high_q <= tmo_stuck_high ? CNT_MAX : '0;
      end
    end
  end

`ifdef PWM_CAP_IRQ_EN
  always_ff @(posedge clk) begin
    if (rst) irq <= 1'b0;
    else     irq <= ie_q & (vld_q | tmo_q);
  end
`endif

  always_comb begin
    per16               = '0;
    high16              = '0;
    per16[CNT_W-1:0]    = per_q;
    high16[CNT_W-1:0]   = high_q;
    rdata               = '0;
    unique case (addr)
      4'h0: rdata = per16[7:0];
      4'h1: rdata = per16[15:8];
      4'h4: rdata = high16[7:0];
      4'h5: rdata = high16[15:8];
`ifdef PWM_CAP_IRQ_EN
      4'h8: rdata = {5'b0, ie_q, freeze_q, en_q};
`else
      4'h8: rdata = {6'b0, freeze_q, en_q};
`endif
      4'h9: rdata = {5'b0, ovr_q, tmo_q, vld_q};
      default: rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: register reads push expected values, a monitor compares.
// CNT_W = 12 keeps timeout runs short; timed-out HIGH then reads 0x0FFF.
module tb_pwm_capture;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wen = 1'b0;
  logic [3:0] addr = '0;
  logic [7:0] wdata = '0;
  logic [7:0] rdata;
  logic       pwm_in = 1'b0;
`ifdef PWM_CAP_IRQ_EN
  logic       irq;
`endif

  logic       rd_strobe = 1'b0;
  string      name_q[$];
  logic [7:0] exp_q[$];
  int         checks = 0;
  int         passes = 0;

  always #5 clk = ~clk;

  pwm_capture #(.SYNC_STAGES(2), .CNT_W(12)) dut (
    .clk(clk),
    .rst(rst),
    .wen(wen),
    .addr(addr),
    .wdata(wdata),
    .rdata(rdata),
    .pwm_in(pwm_in)
`ifdef PWM_CAP_IRQ_EN
    ,
    .irq(irq)
`endif
  );

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] e);
    checks++;
    if (act === e) passes++;
    else $display("FAIL %s: got 0x%02h expected 0x%02h", nm, act, e);
  endtask

  initial begin
    string      nm;
    logic [7:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (rd_strobe) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL scoreboard_underflow: read with no expected value queued");
        end else begin
          nm = name_q.pop_front();
          e  = exp_q.pop_front();
          check(nm, rdata, e);
        end
      end
    end
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_pin(input logic v);
    @(negedge clk);
    pwm_in = v;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    wen = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    wen = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [7:0] e, input string nm);
    @(negedge clk);
    addr = a;
    rd_strobe = 1'b1;
    name_q.push_back(nm);
    exp_q.push_back(e);
    @(negedge clk);
    rd_strobe = 1'b0;
  endtask

  // High for h cycles then low for l cycles; rises of consecutive calls are h+l apart
  task automatic pulse(input int unsigned h, input int unsigned l);
    @(negedge clk);
    pwm_in = 1'b1;
    repeat (h - 1) @(negedge clk);
    @(negedge clk);
    pwm_in = 1'b0;
    repeat (l - 1) @(negedge clk);
  endtask

  initial begin
    tick(2);
    rst = 1'b0;

    // reset state and EN=0 behaviour
    for (int i = 0; i < 16; i++) rd(4'(i), 8'h00, $sformatf("reset_sweep_%0h", i));
`ifdef PWM_CAP_IRQ_EN
    check("irq_reset", {7'b0, irq}, 8'h00);
`endif
    repeat (3) pulse(5, 5);
    rd(4'h9, 8'h00, "status_en_off");

    // period 100, high 40
    wr(4'h8, 8'h01);
    tick(2);
    pulse(40, 60);
    fork
      pulse(40, 60);
      begin
        tick(4);
        rd(4'h0, 8'h64, "per_lo_100");
        rd(4'h1, 8'h00, "per_hi_100");
        rd(4'h4, 8'h28, "high_lo_40");
        rd(4'h5, 8'h00, "high_hi_40");
        rd(4'h9, 8'h01, "status_vld");
      end
    join

    // overrun, then W1C in the same cycle as a commit
    fork
      pulse(40, 60);
      begin tick(4); rd(4'h9, 8'h05, "status_ovr"); end
    join
    fork
      pulse(40, 60);
      begin
        tick(2);
        wr(4'h9, 8'h05);
        tick(2);
        rd(4'h9, 8'h01, "w1c_vs_commit");
        rd(4'h0, 8'h64, "per_after_w1c");
      end
    join

    // freeze
    wr(4'h9, 8'h07);
    wr(4'h8, 8'h03);
    fork
      pulse(60, 40);
      begin tick(4); wr(4'h9, 8'h07); end
    join
    fork
      pulse(60, 40);
      begin
        tick(4);
        rd(4'h4, 8'h28, "high_frozen");
        rd(4'h0, 8'h64, "per_frozen");
        rd(4'h9, 8'h01, "vld_frozen");
        rd(4'h8, 8'h03, "ctrl_freeze");
        wr(4'h9, 8'h07);
        wr(4'h8, 8'h01);
      end
    join
    fork
      pulse(60, 40);
      begin
        tick(4);
        rd(4'h4, 8'h3C, "high_60");
        rd(4'h0, 8'h64, "per_unfrozen");
        rd(4'h9, 8'h01, "status_unfrozen");
        wr(4'h8, 8'h00);
        tick(2);
        rd(4'h4, 8'h3C, "high_kept");
        rd(4'h0, 8'h64, "per_kept");
        rd(4'h9, 8'h01, "status_kept");
      end
    join
    wr(4'h9, 8'h07);
    pulse(30, 30);
    pulse(30, 30);
    rd(4'h9, 8'h00, "idle_no_status");

    // timeout, stuck high then stuck low
    wr(4'h8, 8'h01);
    tick(2);
    set_pin(1'b1);
    tick(4200);
    rd(4'h9, 8'h02, "tmo_high_status");
    rd(4'h0, 8'h00, "tmo_high_per_lo");
    rd(4'h1, 8'h00, "tmo_high_per_hi");
    rd(4'h4, 8'hFF, "tmo_high_high_lo");
    rd(4'h5, 8'h0F, "tmo_high_high_hi");
    wr(4'h9, 8'h07);
    set_pin(1'b0);
    tick(5);
    set_pin(1'b1);
    tick(10);
    set_pin(1'b0);
    tick(4200);
    rd(4'h9, 8'h02, "tmo_low_status");
    rd(4'h4, 8'h00, "tmo_low_high_lo");
    rd(4'h5, 8'h00, "tmo_low_high_hi");
    rd(4'h0, 8'h00, "tmo_low_per_lo");

    // IE bit / irq
    wr(4'h9, 8'h07);
    wr(4'h8, 8'h05);
    pulse(20, 20);
    fork
      pulse(20, 20);
      begin
`ifdef PWM_CAP_IRQ_EN
        tick(4);
        check("irq_before", {7'b0, irq}, 8'h00);
        tick(1);
        check("irq_rise", {7'b0, irq}, 8'h01);
        wr(4'h9, 8'h01);
        check("irq_held", {7'b0, irq}, 8'h01);
        tick(1);
        check("irq_fall", {7'b0, irq}, 8'h00);
        rd(4'h8, 8'h05, "ctrl_ie");
`else
        tick(4);
        rd(4'h8, 8'h01, "ctrl_no_ie");
`endif
        rd(4'h0, 8'h28, "per_40");
        rd(4'h4, 8'h14, "high_20");
      end
    join

    // reset mid-measurement
    set_pin(1'b1);
    tick(5);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rd(4'h0, 8'h00, "per_after_rst");
    rd(4'h4, 8'h00, "high_after_rst");
    rd(4'h8, 8'h00, "ctrl_after_rst");
    rd(4'h9, 8'h00, "status_after_rst");

    tick(3);
    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("FAIL scoreboard_drain: %0d pending, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
